// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFFFFFF;
    localparam logic [31:0] OVF_QUOT  = 32'h80000000;

endpackage

// File: rtl/muldiv_if.sv
// Request/response handshake bundle between the execute stage and muldiv_unit.
interface muldiv_if;
    import muldiv_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [2:0]      func3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, func3, a, b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, func3, a, b, out_ready,
        output in_ready, out_valid, result, busy
    );

endinterface

// File: rtl/div_core.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module div_core (
    input  logic [32:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] divisor_i,
    output logic [32:0] rem_o,
    output logic [31:0] quo_o
);

    logic [32:0] shifted;
    logic [33:0] diff;
    logic        fits;

    always_comb begin
        shifted = {rem_i[31:0], quo_i[31]};
        diff    = {1'b0, shifted} - {2'b00, divisor_i};
        // rem_i[32] set would mean the shifted value already exceeds any divisor
        fits    = rem_i[32] | ~diff[33];
        if (fits) begin
            rem_o = diff[32:0];
            quo_o = {quo_i[30:0], 1'b1};
        end else begin
            rem_o = shifted;
            quo_o = {quo_i[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide sequencer: one-cycle multiply, 32-step restoring divide.
module muldiv_unit
    import muldiv_pkg::*;
(
    input logic     clk,
    input logic     rst,
    input logic     flush,
    muldiv_if.slave mif
);

    state_e      state_q;
    logic [1:0]  op_q;
    logic [31:0] opa_q;
    logic [31:0] opb_q;
    logic [32:0] rem_q;
    logic        qneg_q;
    logic        rneg_q;
    logic [5:0]  cnt_q;
    logic [31:0] result_q;

    // Accept-time decode of the incoming request
    logic        sgn_div;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] special_res;

    always_comb begin
        sgn_div     = ~mif.func3[0];
        a_neg       = sgn_div & mif.a[31];
        b_neg       = sgn_div & mif.b[31];
        a_mag       = a_neg ? -mif.a : mif.a;
        b_mag       = b_neg ? -mif.b : mif.b;
        div_zero    = (mif.b == '0);
        div_ovf     = sgn_div & (mif.a == OVF_QUOT) & (mif.b == DIV0_QUOT);
        if (div_zero) begin
            special_res = mif.func3[1] ? mif.a : DIV0_QUOT;
        end else begin
            special_res = mif.func3[1] ? '0 : OVF_QUOT;
        end
    end

    logic               mul_sa;
    logic               mul_sb;
    logic signed [63:0] mul_a;
    logic signed [63:0] mul_b;
    logic signed [63:0] prod;

    always_comb begin
        mul_sa = (op_q == F3_MULH[1:0]) | (op_q == F3_MULHSU[1:0]);
        mul_sb = (op_q == F3_MULH[1:0]);
        mul_a  = {{32{mul_sa & opa_q[31]}}, opa_q};
        mul_b  = {{32{mul_sb & opb_q[31]}}, opb_q};
        prod   = mul_a * mul_b;
    end

    logic [32:0] rem_nx;
    logic [31:0] quo_nx;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    div_core u_div_core (
        .rem_i     (rem_q),
        .quo_i     (opa_q),
        .divisor_i (opb_q),
        .rem_o     (rem_nx),
        .quo_o     (quo_nx)
    );

    always_comb begin
        quo_fix = qneg_q ? -quo_nx : quo_nx;
        rem_fix = rneg_q ? -rem_nx[31:0] : rem_nx[31:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            rem_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (flush) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mif.in_valid) begin
                        op_q <= mif.func3[1:0];
                        if (!mif.func3[2]) begin
                            opa_q   <= mif.a;
                            opb_q   <= mif.b;
                            state_q <= StMul;
                        end else if (div_zero || div_ovf) begin
                            result_q <= special_res;
                            state_q  <= StDone;
                        end else begin
                            // opa_q doubles as dividend shifter and quotient accumulator
                            opa_q   <= a_mag;
                            opb_q   <= b_mag;
                            rem_q   <= '0;
                            qneg_q  <= a_neg ^ b_neg;
                            rneg_q  <= a_neg;
                            cnt_q   <= 6'd31;
                            state_q <= StDiv;
                        end
                    end
                end
                StMul: begin
                    result_q <= (op_q == F3_MUL[1:0]) ? prod[31:0] : prod[63:32];
                    state_q  <= StDone;
                end
                StDiv: begin
                    rem_q <= rem_nx;
                    opa_q <= quo_nx;
                    if (cnt_q == '0) begin
                        result_q <= op_q[1] ? rem_fix : quo_fix;
                        state_q  <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 6'd1;
                    end
                end
                StDone: begin
                    if (mif.out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mif.in_ready  = (state_q == StIdle);
    assign mif.out_valid = (state_q == StDone);
    assign mif.busy      = (state_q != StIdle);
    assign mif.result    = result_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle controller and datapath for the RV32M multiply/divide group. The execute stage routes R-type instructions with func7[0]=1 here; the base-ISA combinational ALU keeps all other operations. The unit sequences a registered multiply and a 32-step restoring divider, and handles RISC-V divide-by-zero and overflow results. A valid/ready handshake on each side lets the pipeline stall while the unit is busy.

## Interface
- XLEN, 32, operand/result width; only 32 is supported
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  abandon in-flight op (pipeline redirect)
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept; high only in IDLE
- func3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  XLEN  rs1 operand
- b  in  XLEN  rs2 operand
- out_valid  out  1  result available; held until accepted
- out_ready  in  1  consumer takes result
- result  out  XLEN  rd value
- busy  out  1  state != IDLE (stall hint)

## Operation
- States: IDLE, MUL, DIV, DONE.
- Accept = in_valid && in_ready, sampled at edge T. On accept, func3, a and b are latched.
- IDLE -> MUL when func3[2]=0.
- IDLE -> DONE directly for a DIV-class special case: b=0, or signed overflow (a=0x80000000, b=0xFFFFFFFF with func3 100/110).
- IDLE -> DIV for all other func3[2]=1 operations.
- MUL, one cycle: form the 64-bit product.
  - Sign-extend both operands for MULH.
  - Sign-extend a and zero-extend b for MULHSU.
  - Zero-extend both for MULHU.
  - MUL returns the low word; the other three return the high word.
  - MUL -> DONE.
- DIV: restoring divide on magnitudes.
  - Signed ops negate negative operands on accept.
  - 32 iterations, one quotient bit per cycle (MSB first), with a 33-bit partial remainder.
  - After the last iteration, sign-fix is applied: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - DIV -> DONE.
- Special results, per the RISC-V spec:
  - Divide by zero: DIV/DIVU result = 0xFFFFFFFF; REM/REMU result = a.
  - Signed overflow: DIV result = 0x80000000; REM result = 0.
- DONE: out_valid=1 and result stable. DONE -> IDLE on out_ready.
- flush or rst in any state -> IDLE at the next edge; a pending result is discarded with no out_valid. rst takes priority over flush.
- in_valid while not in IDLE is ignored; the requester must hold it.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, busy=0, result=0.
- With accept at edge T:
  - MUL-class: out_valid in cycle T+2.
  - Normal divide: out_valid in cycle T+33.
  - Special case: out_valid in cycle T+1.
- Handshake at edge U (out_valid && out_ready): in_ready=1 in cycle U+1. There is no back-to-back accept in DONE.
- out_ready high in the first DONE cycle gives zero stall cycles.
- Outputs are registered or pure state decodes; there is no combinational path from in_* to out_*.
- flush in the same cycle as an accept: the flush wins and the request is dropped.

## Structure
- muldiv_pkg holds:
  - the state enum;
  - func3 localparams (F3_MUL … F3_REMU);
  - the special-case constants DIV0_QUOT=32'hFFFFFFFF and OVF_QUOT=32'h80000000.
- Sub-module div_core holds the combinational single-step restoring divide: (rem, quo, divisor) -> (rem', quo'). The FSM in muldiv_unit owns the iteration counter (6-bit, counts 31 down to 0) and the operand registers.

## Test plan
- MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, out_valid at T+2.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2; out_valid at T+33, busy high T+1..T+33.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0; each with out_valid at T+1.
- flush in cycle T+10 of a DIV -> IDLE and in_ready=1 at T+11, out_valid never asserted. A following MUL 3×4 -> 12.
- out_ready low 3 cycles in DONE -> out_valid and result held constant and in_ready=0. rst asserted mid-DIV -> all outputs at reset values the next cycle.
